// File: rtl/noc_router_input_vc.sv
// Router input port with VCHANNELS virtual channels. Each VC has a FIFO, a
// header route lookup that holds for the whole packet, and an output register.
module noc_router_input_vc #(
  parameter int                         FLIT_WIDTH   = 256,
  parameter int                         VCHANNELS    = 2,
  parameter int                         OUTPUTS      = 5,
  parameter int                         DESTS        = 16,
  parameter logic [OUTPUTS*DESTS-1:0]   ROUTES       = '0,
  parameter int                         DEST_LSB     = 0,
  parameter int                         BUFFER_DEPTH = 4,
  localparam int                        DEST_W       = (DESTS > 1) ? $clog2(DESTS) : 1,
  localparam int                        CNT_W        = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [FLIT_WIDTH-1:0]                 in_flit,
  input  logic                                  in_last,
  input  logic [VCHANNELS-1:0]                  in_valid,
  output logic [VCHANNELS-1:0]                  in_ready,
  output logic [VCHANNELS-1:0][FLIT_WIDTH-1:0]  out_flit,
  output logic [VCHANNELS-1:0]                  out_last,
  output logic [VCHANNELS-1:0][OUTPUTS-1:0]     out_valid,
  input  logic [VCHANNELS-1:0][OUTPUTS-1:0]     out_ready,
  output logic [VCHANNELS-1:0][CNT_W-1:0]       occupancy,
  output logic [VCHANNELS-1:0]                  err_route
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

  typedef enum logic [1:0] {ST_HEAD, ST_BODY, ST_DROP} state_e;

  // Destinations outside 0..DESTS-1 fall through to an empty route and get dropped.
  function automatic logic [OUTPUTS-1:0] route_of(input logic [DEST_W-1:0] d);
    logic [OUTPUTS-1:0] r;
    r = '0;
    for (int i = 0; i < DESTS; i++)
      if (DEST_W'(i) == d) r = ROUTES[i*OUTPUTS +: OUTPUTS];
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  for (genvar v = 0; v < VCHANNELS; v++) begin : g_vc
    logic [FLIT_WIDTH:0]    mem_q [BUFFER_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]       cnt_q;
    state_e                 state_q, state_d;
    logic [OUTPUTS-1:0]     route_q, route_d, load_route, hdr_route, rt_q;
    logic                   full_q, last_q, err_q;
    logic [FLIT_WIDTH-1:0]  flit_q, head_flit;
    logic                   head_last, empty, push, pop, load, drop_hdr, xfer, stage_free;

    assign empty        = (cnt_q == '0);
    assign in_ready[v]  = (cnt_q != CNT_W'(BUFFER_DEPTH));
    assign push         = in_valid[v] & in_ready[v];
    assign {head_last, head_flit} = mem_q[rd_ptr_q];
    assign hdr_route    = route_of(head_flit[DEST_LSB +: DEST_W]);
    assign xfer         = full_q & (|(rt_q & out_ready[v]));
    assign stage_free   = ~full_q | xfer;

    always_comb begin
      state_d    = state_q;
      route_d    = route_q;
      load_route = route_q;
      pop        = 1'b0;
      load       = 1'b0;
      drop_hdr   = 1'b0;
      case (state_q)
        ST_HEAD: if (!empty) begin
          if (hdr_route == '0) begin
            pop      = 1'b1;
            drop_hdr = 1'b1;
            state_d  = head_last ? ST_HEAD : ST_DROP;
          end else if (stage_free) begin
            pop        = 1'b1;
            load       = 1'b1;
            load_route = hdr_route;
            route_d    = hdr_route;
            state_d    = head_last ? ST_HEAD : ST_BODY;
          end
        end
        ST_BODY: if (!empty && stage_free) begin
          pop  = 1'b1;
          load = 1'b1;
          if (head_last) state_d = ST_HEAD;
        end
        ST_DROP: if (!empty) begin
          pop = 1'b1;
          if (head_last) state_d = ST_HEAD;
        end
        default: state_d = ST_HEAD;
      endcase
    end

    // FIFO control, packet FSM and output register stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= ST_HEAD;
        route_q  <= '0;
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        cnt_q    <= '0;
        full_q   <= 1'b0;
        flit_q   <= '0;
        last_q   <= 1'b0;
        rt_q     <= '0;
        err_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        route_q <= route_d;
        err_q   <= drop_hdr;
        if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
        if (push && !pop)      cnt_q <= cnt_q + CNT_W'(1);
        else if (pop && !push) cnt_q <= cnt_q - CNT_W'(1);
        if (load) begin
          full_q <= 1'b1;
          flit_q <= head_flit;
          last_q <= head_last;
          rt_q   <= load_route;
        end else if (xfer) begin
          full_q <= 1'b0;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_last, in_flit};
    end

    assign out_flit[v]  = flit_q;
    assign out_last[v]  = last_q;
    assign out_valid[v] = full_q ? rt_q : '0;
    assign occupancy[v] = cnt_q;
    assign err_route[v] = err_q;
  end

  a_onehot_valid: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_valid))
    else $error("multiple in_valid bits set in one cycle");

endmodule

// File: tb/tb_noc_router_input_vc.sv
// Bench for noc_router_input_vc: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_noc_router_input_vc;

  function automatic logic [79:0] mk_routes();
    logic [79:0] r;
    r = '0;
    for (int d = 0; d < 15; d++) r[d*5 +: 5] = 5'(1 << (d % 5));
    return r;
  endfunction

  localparam logic [79:0] ROUTES_P = mk_routes();

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [15:0]           in_flit = '0;
  logic                  in_last = 1'b0;
  logic [1:0]            in_valid = '0;
  logic [1:0]            in_ready;
  logic [1:0][15:0]      out_flit;
  logic [1:0]            out_last;
  logic [1:0][4:0]       out_valid;
  logic [1:0][4:0]       out_ready = '0;
  logic [1:0][2:0]       occupancy;
  logic [1:0]            err_route;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  noc_router_input_vc #(
    .FLIT_WIDTH(16), .VCHANNELS(2), .OUTPUTS(5), .DESTS(16),
    .ROUTES(ROUTES_P), .DEST_LSB(0), .BUFFER_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_flit(in_flit), .in_last(in_last),
    .in_valid(in_valid), .in_ready(in_ready), .out_flit(out_flit),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .err_route(err_route)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int vc, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s vc%0d got=%0h want=%0h", nm, vc, act, exp);
    end
  endtask

  // Reference model: the route of a destination, per-VC packet queues, and
  // a one-entry output slot per VC.
  function automatic logic [4:0] route_for(input logic [15:0] f);
    int d;
    d = int'(f[3:0]);
    return (d == 15) ? 5'd0 : 5'(1 << (d % 5));
  endfunction

  logic [16:0] mq [2][$];
  int          mmode  [2];
  logic [4:0]  mroute [2];
  logic        mfull  [2];
  logic [15:0] mflit  [2];
  logic        mlast  [2];
  logic [4:0]  mrt    [2];
  logic        merr   [2];
  logic [16:0] mh;
  logic [4:0]  mr;
  logic        macc, mxfer, mfree;

  initial begin
    for (int v = 0; v < 2; v++) begin
      mmode[v] = 0; mroute[v] = '0; mfull[v] = 1'b0; mflit[v] = '0;
      mlast[v] = 1'b0; mrt[v] = '0; merr[v] = 1'b0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < 2; v++) begin
        mq[v].delete();
        mmode[v] = 0; mroute[v] = '0; mfull[v] = 1'b0; mflit[v] = '0;
        mlast[v] = 1'b0; mrt[v] = '0; merr[v] = 1'b0;
      end
    end else begin
      for (int v = 0; v < 2; v++) begin
        macc  = in_valid[v] && (mq[v].size() < 4);
        mxfer = mfull[v] && (|(mrt[v] & out_ready[v]));
        mfree = !mfull[v] || mxfer;
        merr[v] = 1'b0;
        if (mxfer) mfull[v] = 1'b0;
        if (mq[v].size() > 0) begin
          mh = mq[v][0];
          if (mmode[v] == 0) begin
            mr = route_for(mh[15:0]);
            if (mr == 5'd0) begin
              void'(mq[v].pop_front());
              merr[v] = 1'b1;
              mmode[v] = mh[16] ? 0 : 2;
            end else if (mfree) begin
              void'(mq[v].pop_front());
              mfull[v] = 1'b1; mflit[v] = mh[15:0]; mlast[v] = mh[16]; mrt[v] = mr;
              mroute[v] = mr;
              mmode[v] = mh[16] ? 0 : 1;
            end
          end else if (mmode[v] == 1) begin
            if (mfree) begin
              void'(mq[v].pop_front());
              mfull[v] = 1'b1; mflit[v] = mh[15:0]; mlast[v] = mh[16]; mrt[v] = mroute[v];
              if (mh[16]) mmode[v] = 0;
            end
          end else begin
            void'(mq[v].pop_front());
            if (mh[16]) mmode[v] = 0;
          end
        end
        if (macc) mq[v].push_back({in_last, in_flit});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int v = 0; v < 2; v++) begin
        check("in_ready", v, 64'(in_ready[v]), 64'(mq[v].size() < 4));
        check("occupancy", v, 64'(occupancy[v]), 64'(mq[v].size()));
        check("out_valid", v, 64'(out_valid[v]), 64'(mfull[v] ? mrt[v] : 5'd0));
        check("err_route", v, 64'(err_route[v]), 64'(merr[v]));
        if (mfull[v]) begin
          check("out_flit", v, 64'(out_flit[v]), 64'(mflit[v]));
          check("out_last", v, 64'(out_last[v]), 64'(mlast[v]));
        end
      end
    end
  end

  task automatic drive(input int v, input logic [15:0] f, input logic l);
    in_valid = 2'(1 << v);
    in_flit  = f;
    in_last  = l;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = '0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 0, 64'(in_ready), 64'h3);
    check("rst_out_valid", 0, 64'(out_valid), 64'h0);
    check("rst_occupancy", 0, 64'(occupancy), 64'h0);
    check("rst_err", 0, 64'(err_route), 64'h0);
    check("rst_out_flit", 0, 64'(out_flit), 64'h0);
    check("rst_out_last", 0, 64'(out_last), 64'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // three-flit packet to dest 2 on VC0
    out_ready = {5'h1F, 5'h1F};
    drive(0, 16'h0A02, 1'b0);
    drive(0, 16'h0B00, 1'b0);
    check("t1_route_c1", 0, 64'(out_valid[0]), 64'b00100);
    check("t1_hdr_flit", 0, 64'(out_flit[0]), 64'h0A02);
    drive(0, 16'h0C00, 1'b1);
    check("t1_route_c2", 0, 64'(out_valid[0]), 64'b00100);
    check("t1_body_flit", 0, 64'(out_flit[0]), 64'h0B00);
    idle(1);
    check("t1_route_c3", 0, 64'(out_valid[0]), 64'b00100);
    check("t1_last", 0, 64'(out_last[0]), 64'h1);
    idle(1);
    check("t1_done", 0, 64'(out_valid[0]), 64'h0);
    idle(2);

    // back-to-back single-flit packets to dest 0,1,2
    drive(0, 16'h3000, 1'b1);
    drive(0, 16'h3101, 1'b1);
    check("t4_first", 0, 64'(out_valid[0]), 64'b00001);
    drive(0, 16'h3202, 1'b1);
    check("t4_second", 0, 64'(out_valid[0]), 64'b00010);
    check("t4_second_flit", 0, 64'(out_flit[0]), 64'h3101);
    idle(1);
    check("t4_third", 0, 64'(out_valid[0]), 64'b00100);
    idle(1);
    check("t4_done", 0, 64'(out_valid[0]), 64'h0);
    idle(2);

    // unroutable dest 15, four flits, then dest 1 routed normally
    drive(0, 16'h000F, 1'b0);
    check("t3_no_err_yet", 0, 64'(err_route[0]), 64'h0);
    drive(0, 16'h1111, 1'b0);
    check("t3_err_pulse", 0, 64'(err_route[0]), 64'h1);
    drive(0, 16'h1222, 1'b0);
    check("t3_err_once", 0, 64'(err_route[0]), 64'h0);
    drive(0, 16'h1333, 1'b1);
    check("t3_no_out", 0, 64'(out_valid[0]), 64'h0);
    drive(0, 16'h2201, 1'b1);
    idle(1);
    check("t3_next_route", 0, 64'(out_valid[0]), 64'b00010);
    check("t3_next_flit", 0, 64'(out_flit[0]), 64'h2201);
    idle(2);

    // VC1 stalled and filled while VC0 drains
    out_ready = '0;
    drive(0, 16'h5000, 1'b0);
    drive(0, 16'h5111, 1'b0);
    drive(0, 16'h5222, 1'b1);
    out_ready[0] = 5'h1F;
    drive(1, 16'h6003, 1'b0);
    drive(1, 16'h6111, 1'b0);
    drive(1, 16'h6222, 1'b0);
    drive(1, 16'h6333, 1'b0);
    drive(1, 16'h6444, 1'b1);
    check("t2_occ_full", 1, 64'(occupancy[1]), 64'h4);
    check("t2_not_ready", 1, 64'(in_ready[1]), 64'h0);
    check("t2_stalled_route", 1, 64'(out_valid[1]), 64'b01000);
    check("t2_vc0_drained", 0, 64'(out_valid[0]), 64'h0);
    check("t2_vc0_empty", 0, 64'(occupancy[0]), 64'h0);

    // full FIFO popped while input is offered: refused, then accepted
    in_valid = 2'b10; in_flit = 16'h7001; in_last = 1'b1;
    out_ready[1] = 5'h1F;
    @(negedge clk);
    check("t5_occ_after_pop", 1, 64'(occupancy[1]), 64'h3);
    check("t5_ready_again", 1, 64'(in_ready[1]), 64'h1);
    out_ready[1] = 5'h00;
    @(negedge clk);
    check("t5_occ_refill", 1, 64'(occupancy[1]), 64'h4);
    out_ready[1] = 5'h1F;
    idle(8);
    check("t5_vc1_drained", 1, 64'(out_valid[1]), 64'h0);
    check("t5_vc1_empty", 1, 64'(occupancy[1]), 64'h0);

    // reset mid-packet
    out_ready[0] = 5'h00;
    drive(0, 16'h8002, 1'b0);
    idle(1);
    check("t6_hdr_held", 0, 64'(out_valid[0]), 64'b00100);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", 0, 64'(out_valid), 64'h0);
    check("t6_rst_in_ready", 0, 64'(in_ready), 64'h3);
    check("t6_rst_occ", 0, 64'(occupancy), 64'h0);
    check("t6_rst_flit", 0, 64'(out_flit), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[0] = 5'h1F;
    drive(0, 16'h9001, 1'b1);
    idle(1);
    check("t6_new_header", 0, 64'(out_valid[0]), 64'b00010);
    check("t6_new_flit", 0, 64'(out_flit[0]), 64'h9001);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
